// File: rtl/fairy_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface fairy_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             cancel;
    logic             busy;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op0, op1, cancel,
        input  busy, stall, valid, hi, lo
    );

    modport slave (
        input  start, op, op0, op1, cancel,
        output busy, stall, valid, hi, lo
    );
endinterface

// File: rtl/fairy_muldiv_unit.sv
// Iterative signed/unsigned MULT/DIV producing {hi, lo}; WIDTH+1 cycles to valid (1 for fast multiply).
// No queuing: start is only taken in IDLE/DONE, stall holds the pipeline while CALC is running.
module fairy_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    fairy_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, raw0_q;
    logic                 is_div_q, neg_p_q, neg_r_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 accept, fast_go, finish;
    logic                 s0, s1;
    logic [WIDTH-1:0]     mag0_in, mag1_in;
    logic [WIDTH:0]       rem_sh, diff, sum;
    logic [2*WIDTH-1:0]   res_calc, prod_fast, res_fast;

    assign accept  = (state_q != S_CALC) && bus.start && !bus.cancel;
    assign fast_go = FAST_MUL && !bus.op[1];
    assign finish  = (state_q == S_CALC) && (cnt_q == CW'(1)) && !bus.cancel;

    // op[0]==0 selects the signed flavour of both MULT and DIV
    assign s0      = !bus.op[0] && bus.op0[WIDTH-1];
    assign s1      = !bus.op[0] && bus.op1[WIDTH-1];
    assign mag0_in = s0 ? -bus.op0 : bus.op0;
    assign mag1_in = s1 ? -bus.op1 : bus.op1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = fast_go ? S_DONE : S_CALC;
                else        state_d = S_IDLE;
            end
            S_CALC:  if (cnt_q == CW'(1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (bus.cancel) state_d = S_IDLE;
    end

    // acc holds {partial remainder, dividend/quotient} for divide and the
    // shifting {partial product, multiplier} pair for multiply.
    always_comb begin
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_q};
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        if (is_div_q) begin
            if (diff[WIDTH]) acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else             acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        res_calc = neg_p_q ? -acc_d : acc_d;
        if (is_div_q) begin
            if (b_q == '0) begin
                res_calc = {raw0_q, {WIDTH{1'b1}}};
            end else begin
                res_calc[WIDTH-1:0]       = neg_p_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
                res_calc[2*WIDTH-1:WIDTH] = neg_r_q ? -acc_d[2*WIDTH-1:WIDTH]
                                                    : acc_d[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign prod_fast = (2*WIDTH)'(mag0_in) * (2*WIDTH)'(mag1_in);
    assign res_fast  = (s0 ^ s1) ? -prod_fast : prod_fast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            raw0_q   <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (bus.cancel) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q    <= fast_go ? '0 : CW'(WIDTH);
                acc_q    <= {{WIDTH{1'b0}}, mag0_in};
                b_q      <= mag1_in;
                raw0_q   <= bus.op0;
                is_div_q <= bus.op[1];
                neg_p_q  <= s0 ^ s1;
                neg_r_q  <= s0;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q - CW'(1);
                acc_q <= acc_d;
            end
            if (finish)                {hi_q, lo_q} <= res_calc;
            else if (accept && fast_go) {hi_q, lo_q} <= res_fast;
        end
    end

    assign bus.busy  = (state_q == S_CALC);
    assign bus.stall = bus.busy || accept;
    assign bus.valid = (state_q == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_fairy_muldiv_unit.sv
// Scoreboard bench: a fast-multiply and an iterative-multiply unit driven with identical directed vectors.
module tb_fairy_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0, reset_n = 1'b1;
    logic start = 1'b0, cancel = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int nf, ns;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;
    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x, y, hi, lo;
    } vec_t;

    exp_t qf[$], qs[$];
    vec_t vecs[9];

    fairy_muldiv_unit_if #(.WIDTH(W)) bf (), bs ();
    assign bf.start = start;  assign bs.start = start;
    assign bf.op = op;        assign bs.op = op;
    assign bf.op0 = a;        assign bs.op0 = a;
    assign bf.op1 = b;        assign bs.op1 = b;
    assign bf.cancel = cancel; assign bs.cancel = cancel;

    fairy_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_f (.clk(clk), .reset_n(reset_n), .bus(bf));
    fairy_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bs));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_res(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input exp_t e);
        n_cmp++;
        if (hi !== e.hi || lo !== e.lo || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s_result: got hi=%h lo=%h cycle=%0d, want hi=%h lo=%h cycle=%0d",
                     tag, hi, lo, cyc, e.hi, e.lo, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && bf.valid === 1'b1) begin
            if (!start) chk("fast_stall_in_done", 64'(bf.stall), 64'd0);
            if (qf.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL fast_unexpected_valid: got hi=%h lo=%h at cycle %0d, want no result",
                         bf.hi, bf.lo, cyc);
            end else begin
                e = qf.pop_front();
                cmp_res("fast", bf.hi, bf.lo, e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && bs.valid === 1'b1) begin
            if (!start) chk("slow_stall_in_done", 64'(bs.stall), 64'd0);
            if (qs.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL slow_unexpected_valid: got hi=%h lo=%h at cycle %0d, want no result",
                         bs.hi, bs.lo, cyc);
            end else begin
                e = qs.pop_front();
                cmp_res("slow", bs.hi, bs.lo, e);
            end
        end
    end

    // Called at a negedge; start is sampled at the next rising edge (edge 0).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk("stall_on_accept", 64'({bf.stall, bs.stall}), 64'b11);
        qf.push_back('{eh, el, cyc + (o[1] ? 33 : 1)});
        qs.push_back('{eh, el, cyc + 33});
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~x; b = 32'h3;
    endtask

    task automatic drain(output int cf, output int cs);
        cf = 0; cs = 0;
        for (int i = 0; i < 100; i++) begin
            if (qf.size() == 0 && qs.size() == 0) break;
            if (bf.busy) cf++;
            if (bs.busy) cs++;
            @(negedge clk);
        end
        chk("drain_done", 64'(qf.size() + qs.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6] = '{DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[7] = '{MULTU, 32'd12345,    32'd0,        32'd0,        32'd0};
        vecs[8] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

        #3 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 64'({bf.busy, bf.stall, bf.valid, bs.busy, bs.stall, bs.valid}), 64'd0);
        chk("rst_fast_hilo", {bf.hi, bf.lo}, 64'd0);
        chk("rst_slow_hilo", {bs.hi, bs.lo}, 64'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].hi, vecs[i].lo);
            drain(nf, ns);
            chk("busy_cycles_fast", 64'(nf), vecs[i].op[1] ? 64'd32 : 64'd0);
            chk("busy_cycles_slow", 64'(ns), 64'd32);
        end

        // Cancel in cycle 10 of DIVU 100/7 with {2,14} already held
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        chk("busy_before_cancel", 64'({bf.busy, bs.busy}), 64'b11);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy_drop", 64'({bf.busy, bs.busy}), 64'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hold_fast", {bf.hi, bf.lo}, {32'd2, 32'd14});
        chk("cancel_hold_slow", {bs.hi, bs.lo}, {32'd2, 32'd14});

        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = MULT; a = 32'd3; b = 32'd5;
        #1;
        chk("start_cancel_stall", 64'({bf.stall, bs.stall}), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_idle", 64'({bf.busy, bf.valid, bs.busy, bs.valid}), 64'd0);

        // Start while CALC must be dropped
        @(negedge clk);
        issue(DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        repeat (5) @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
        #1;
        chk("stall_while_busy", 64'({bf.stall, bs.stall}), 64'b11);
        @(negedge clk);
        start = 1'b0;
        drain(nf, ns);
        repeat (40) @(negedge clk);
        chk("ignored_start_idle", 64'({bf.busy, bs.busy}), 64'd0);
        chk("ignored_start_hold", {bs.hi, bs.lo}, {32'd1, 32'hFFFFFFFD});

        // Back-to-back: new start in the DONE cycle
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        for (int i = 0; i < 60; i++) begin
            if (bs.valid) break;
            @(negedge clk);
        end
        chk("b2b_reached_done", 64'(bs.valid), 64'd1);
        issue(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        drain(nf, ns);
        chk("b2b_busy_fast", 64'(nf), 64'd32);
        chk("b2b_busy_slow", 64'(ns), 64'd32);

        // Reset in cycle 5 of a DIV
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'hFFFFFFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midop_rst_ctl", 64'({bf.busy, bf.stall, bf.valid, bs.busy, bs.stall, bs.valid}), 64'd0);
        chk("midop_rst_fast_hilo", {bf.hi, bf.lo}, 64'd0);
        chk("midop_rst_slow_hilo", {bs.hi, bs.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        @(negedge clk);
        issue(MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        drain(nf, ns);
        repeat (3) @(negedge clk);
        chk("queues_empty", 64'(qf.size() + qs.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
